// File: rtl/bow_ctrl_pkg.sv
// Shared types and constants for the bow sprite controller.
package bow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAW     = 2'd1,
    ST_FULL     = 2'd2,
    ST_COOLDOWN = 2'd3
  } bow_state_e;

  localparam int NUM_BOW_FRAMES          = 5;
  localparam int DEFAULT_HOLD_FRAMES     = 6;
  localparam int DEFAULT_COOLDOWN_FRAMES = 15;

  // Last bow frame: fully drawn.
  localparam logic [2:0] FULL_SEL = 3'(NUM_BOW_FRAMES - 1);

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous level input.
module btn_sync (
  input  logic vga_clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic btn_s
);

  logic btn_meta;

  // Shift the raw level through two flops; both clear on reset.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
    end
  end

endmodule

// File: rtl/bow_sprite_ctrl.sv
// Bow draw/release controller and sprite compositor.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | bow at rest (frame 0), waiting for a held button on a tick
// ST_DRAW     | drawing: bow_sel advances every HOLD_FRAMES ticks
// ST_FULL     | fully drawn (frame 4), waiting for release
// ST_COOLDOWN | shot taken, button ignored for COOLDOWN_FRAMES ticks
module bow_sprite_ctrl
  import bow_ctrl_pkg::*;
#(
  parameter int HOLD_FRAMES     = DEFAULT_HOLD_FRAMES,
  parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
  input  logic                                vga_clk,
  input  logic                                Reset,
  input  logic                                fire_btn,
  input  logic                                frame_tick,
  input  logic [NUM_BOW_FRAMES-1:0][11:0]     spr_rgb,
  input  logic [NUM_BOW_FRAMES-1:0]           spr_a,
  output logic [3:0]                          red,
  output logic [3:0]                          green,
  output logic [3:0]                          blue,
  output logic                                a,
  output logic [2:0]                          bow_sel,
  output logic                                arrow_fire,
  output logic [2:0]                          arrow_power
);

  localparam int STG_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(HOLD_FRAMES - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_FRAMES - 1);

  logic             btn_s;
  bow_state_e       state, state_nxt;
  logic [2:0]       sel_nxt;
  logic [STG_W-1:0] stg_cnt, stg_nxt;
  logic [CD_W-1:0]  cd_cnt, cd_nxt;
  logic [2:0]       power_q, power_nxt;
  logic             fire;

  btn_sync u_btn_sync (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .btn_raw (fire_btn),
    .btn_s   (btn_s)
  );

  // State, frame select, counters and latched shot power.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      bow_sel <= 3'd0;
      stg_cnt <= '0;
      cd_cnt  <= '0;
      power_q <= 3'd0;
    end else begin
      state   <= state_nxt;
      bow_sel <= sel_nxt;
      stg_cnt <= stg_nxt;
      cd_cnt  <= cd_nxt;
      power_q <= power_nxt;
    end
  end

  // Next-state logic; everything moves only on frame_tick so the frame never changes mid-scan.
  always_comb begin
    state_nxt = state;
    sel_nxt   = bow_sel;
    stg_nxt   = stg_cnt;
    cd_nxt    = cd_cnt;
    power_nxt = power_q;
    fire      = 1'b0;
    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (btn_s) begin
            state_nxt = ST_DRAW;
            sel_nxt   = 3'd1;
            stg_nxt   = '0;
          end
        end
        ST_DRAW: begin
          if (!btn_s) begin
            fire = 1'b1;
          end else if (stg_cnt >= STG_LAST) begin
            stg_nxt = '0;
            sel_nxt = bow_sel + 3'd1;
            if (sel_nxt >= FULL_SEL) begin
              sel_nxt   = FULL_SEL;
              state_nxt = ST_FULL;
            end
          end else begin
            stg_nxt = stg_cnt + STG_W'(1);
          end
        end
        ST_FULL: begin
          if (!btn_s) fire = 1'b1;
        end
        ST_COOLDOWN: begin
          if (cd_cnt >= CD_LAST) begin
            cd_nxt    = '0;
            state_nxt = ST_IDLE;
          end else begin
            cd_nxt = cd_cnt + CD_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (fire) begin
      power_nxt = bow_sel;
      sel_nxt   = 3'd0;
      stg_nxt   = '0;
      cd_nxt    = '0;
      state_nxt = ST_COOLDOWN;
    end
  end

  // The shot pulse coincides with the releasing tick; reset suppresses it.
  assign arrow_fire  = fire && !Reset;
  assign arrow_power = arrow_fire ? bow_sel : power_q;

  // Registered sprite lookup; transparent pixels are forced black.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      {red, green, blue} <= 12'h000;
      a                  <= 1'b0;
    end else begin
      {red, green, blue} <= spr_a[bow_sel] ? spr_rgb[bow_sel] : 12'h000;
      a                  <= spr_a[bow_sel];
    end
  end

endmodule

// File: tb/tb_bow_sprite_ctrl.sv
// Randomized bench for bow_sprite_ctrl against a tick-level behavioural model.
module tb_bow_sprite_ctrl;
  import bow_ctrl_pkg::*;

  localparam int HOLD = 2;
  localparam int CDF  = 3;

  logic                               vga_clk = 1'b0;
  logic                               Reset = 1'b1;
  logic                               fire_btn = 1'b0;
  logic                               frame_tick = 1'b0;
  logic [NUM_BOW_FRAMES-1:0][11:0]    spr_rgb;
  logic [NUM_BOW_FRAMES-1:0]          spr_a;
  logic [3:0]                         red, green, blue;
  logic                               a;
  logic [2:0]                         bow_sel;
  logic                               arrow_fire;
  logic [2:0]                         arrow_power;

  bow_sprite_ctrl #(.HOLD_FRAMES(HOLD), .COOLDOWN_FRAMES(CDF)) dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .fire_btn    (fire_btn),
    .frame_tick  (frame_tick),
    .spr_rgb     (spr_rgb),
    .spr_a       (spr_a),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .a           (a),
    .bow_sel     (bow_sel),
    .arrow_fire  (arrow_fire),
    .arrow_power (arrow_power)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  bit rand_tick = 0;
  bit pin_spr = 0;

  // Model: phase 0 = resting, 1 = bow drawn/drawing, 2 = cooling down.
  int         m_phase = 0;
  int         m_held = 0;
  int         m_cd = 0;
  int         m_power = 0;
  logic       m_dly1 = 0, m_dly2 = 0;
  logic [11:0] m_rgb = 0;
  logic       m_a = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Displayed frame: one stage per HOLD ticks held, capped at the full frame.
  function automatic int m_sel();
    int s;
    if (m_phase != 1) return 0;
    s = 1 + m_held / HOLD;
    return (s > 4) ? 4 : s;
  endfunction

  function automatic bit m_fire();
    return frame_tick && !Reset && (m_phase == 1) && !m_dly2;
  endfunction

  // Advance the model across a clock edge using the inputs present before it.
  task automatic model_edge();
    int sel_pre;
    bit f;
    sel_pre = m_sel();
    f = m_fire();
    if (Reset) begin
      m_phase = 0; m_held = 0; m_cd = 0; m_power = 0;
      m_dly1 = 0; m_dly2 = 0; m_rgb = 0; m_a = 0;
    end else begin
      m_a   = spr_a[sel_pre];
      m_rgb = m_a ? spr_rgb[sel_pre] : 12'h000;
      if (frame_tick) begin
        if (f) begin
          m_power = sel_pre;
          m_phase = 2;
          m_cd    = 0;
        end else if (m_phase == 0) begin
          if (m_dly2) begin
            m_phase = 1;
            m_held  = 0;
          end
        end else if (m_phase == 1) begin
          if (m_held < 1000) m_held++;
        end else begin
          m_cd++;
          if (m_cd >= CDF) m_phase = 0;
        end
      end
      m_dly2 = m_dly1;
      m_dly1 = fire_btn;
    end
  endtask

  task automatic check_outs();
    int s;
    bit f;
    s = m_sel();
    f = m_fire();
    chk_val("bow_sel", bow_sel, s);
    chk_val("arrow_fire", arrow_fire, f);
    chk_val("arrow_power", arrow_power, f ? s : m_power);
    chk_val("red", red, m_rgb[11:8]);
    chk_val("green", green, m_rgb[7:4]);
    chk_val("blue", blue, m_rgb[3:0]);
    chk_val("alpha", a, m_a);
  endtask

  task automatic cyc(input logic b, input logic r);
    @(posedge vga_clk);
    model_edge();
    #1;
    cyc_cnt++;
    fire_btn = b;
    Reset = r;
    frame_tick = rand_tick ? ($urandom_range(0, 5) == 0) : (cyc_cnt % 10 == 0);
    if (!pin_spr) begin
      for (int i = 0; i < NUM_BOW_FRAMES; i++) begin
        spr_rgb[i] = 12'($urandom);
        spr_a[i]   = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge vga_clk);
    check_outs();
  endtask

  initial begin
    int k;
    int fires;
    logic [2:0] pw;
    logic b;

    spr_rgb = '0;
    spr_a   = '0;
    repeat (3) cyc(1'b0, 1'b1);
    chk_val("reset_sel", bow_sel, 0);
    chk_val("reset_rgb", {red, green, blue, a}, 0);

    // Long hold: 0 -> 1 -> 2 -> 3 -> 4, then stays, no shot.
    fires = 0;
    repeat (125) begin
      cyc(1'b1, 1'b0);
      if (arrow_fire) fires++;
    end
    chk_val("hold_full", bow_sel, 4);
    chk_val("hold_no_fire", fires, 0);

    // Let go, finish the cooldown, then draw to frame 2 and release.
    repeat (60) cyc(1'b0, 1'b0);
    k = 0;
    while (!(m_phase == 1 && m_sel() == 2) && k < 200) begin
      cyc(1'b1, 1'b0);
      k++;
    end
    chk_val("reach_sel2", bow_sel, 2);
    fires = 0;
    pw = 0;
    repeat (40) begin
      cyc(1'b0, 1'b0);
      if (arrow_fire) begin
        fires++;
        pw = arrow_power;
      end
    end
    chk_val("release_fire_count", fires, 1);
    chk_val("release_power", pw, 2);
    chk_val("release_latched_power", arrow_power, 2);

    // Re-press during cooldown: held through it, draw resumes only from idle.
    k = 0;
    while (m_phase != 1 && k < 200) begin cyc(1'b1, 1'b0); k++; end
    k = 0;
    while (m_phase != 2 && k < 200) begin cyc(1'b0, 1'b0); k++; end
    chk_val("cooldown_entered", bow_sel, 0);
    repeat (80) cyc(1'b1, 1'b0);

    // Short pulses that never reach a tick are ignored.
    repeat (60) cyc(1'b0, 1'b0);
    while ((cyc_cnt + 1) % 10 != 2) cyc(1'b0, 1'b0);
    repeat (20) begin
      for (int j = 0; j < 10; j++) cyc(j == 0, 1'b0);
    end
    chk_val("pulse_ignored", bow_sel, 0);

    // Pixel path at frame 3.
    k = 0;
    while (m_sel() != 3 && k < 200) begin cyc(1'b1, 1'b0); k++; end
    chk_val("reach_sel3", bow_sel, 3);
    pin_spr = 1;
    spr_rgb[3] = 12'hA5C;
    spr_a[3] = 1'b1;
    cyc(1'b1, 1'b0);
    chk_val("pix_red", red, 4'hA);
    chk_val("pix_green", green, 4'h5);
    chk_val("pix_blue", blue, 4'hC);
    chk_val("pix_a", a, 1);
    spr_a[3] = 1'b0;
    cyc(1'b1, 1'b0);
    chk_val("pix_clear_rgb", {red, green, blue}, 0);
    chk_val("pix_clear_a", a, 0);
    pin_spr = 0;

    // Reset at full draw on the same tick that sees the release.
    k = 0;
    while (m_sel() != 4 && k < 200) begin cyc(1'b1, 1'b0); k++; end
    chk_val("reach_full", bow_sel, 4);
    while ((cyc_cnt + 1) % 10 != 7) cyc(1'b1, 1'b0);
    while ((cyc_cnt + 1) % 10 != 0) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk_val("rst_no_fire", arrow_fire, 0);
    cyc(1'b0, 1'b0);
    chk_val("rst_sel", bow_sel, 0);
    chk_val("rst_power", arrow_power, 0);
    chk_val("rst_pix", {red, green, blue, a}, 0);

    // Random phase: irregular ticks, random button runs, occasional reset.
    rand_tick = 1;
    b = 0;
    repeat (3000) begin
      if ($urandom_range(0, 14) == 0) b = ~b;
      cyc(b, ($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
